// File: rtl/load_aligner_pkg.sv
// Shared load/store definitions: access-size encodings, load FSM states and
// the alignment rule. The store byte-masker imports this package as well.
package load_aligner_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_TRI  = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_e;

    // An access is misaligned when its last byte falls past byte lane 3.
    function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
        return ({1'b0, addr} + {1'b0, size}) > 3'd3;
    endfunction

endpackage

// File: rtl/load_aligner_if.sv
// Request, memory-read and response channels of the load aligner.
interface load_aligner_if #(parameter int DATA_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic              mem_rd_en;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_signed, mem_rvalid, mem_rdata, resp_ready,
        output req_ready, mem_rd_en, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_addr, req_size, req_signed, mem_rvalid, mem_rdata, resp_ready,
        input  req_ready, mem_rd_en, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/load_aligner_extend.sv
// load_extend: shifts the addressed bytes down to lane 0, masks to the access
// size and sign- or zero-extends the result. Purely combinational.
module load_extend
    import load_aligner_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  size_e       i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic [31:0] w_mask;
    logic        w_sign;

    always_comb begin
        w_shifted = i_rdata >> {i_addr, 3'b000};
        w_mask    = 32'hFFFF_FFFF;
        w_sign    = 1'b0;
        case (i_size)
            SZ_BYTE: begin w_mask = 32'h0000_00FF; w_sign = w_shifted[7];  end
            SZ_HALF: begin w_mask = 32'h0000_FFFF; w_sign = w_shifted[15]; end
            SZ_TRI:  begin w_mask = 32'h00FF_FFFF; w_sign = w_shifted[23]; end
            SZ_WORD: begin w_mask = 32'hFFFF_FFFF; w_sign = 1'b0;          end
            default: begin w_mask = 32'hFFFF_FFFF; w_sign = 1'b0;          end
        endcase
        o_data = w_shifted & w_mask;
        // Full words have an empty ~w_mask, so they pass through untouched.
        if (i_signed && w_sign) begin
            o_data = o_data | ~w_mask;
        end
    end

endmodule

// File: rtl/load_aligner.sv
// Load aligner: accepts one load at a time, reads the word, then holds the
// aligned/extended result until consumed. Misaligned loads skip the read.
module load_aligner
    import load_aligner_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic          clk,
    input  logic          reset,
    load_aligner_if.slave s_bus
);

    state_e            r_state;
    state_e            w_next;
    logic [1:0]        r_addr;
    size_e             r_size;
    logic              r_signed;
    logic [DATA_W-1:0] r_data;
    logic              r_err;
    logic              r_rd_en;

    logic              w_hs;
    logic              w_mis;
    logic [DATA_W-1:0] w_ext;

    assign s_bus.req_ready  = (r_state == IDLE) && !reset;
    assign s_bus.mem_rd_en  = r_rd_en;
    assign s_bus.resp_valid = (r_state == HOLD);
    assign s_bus.resp_data  = r_data;
    assign s_bus.resp_err   = r_err;

    assign w_hs  = s_bus.req_valid && s_bus.req_ready;
    assign w_mis = is_misaligned(s_bus.req_addr, s_bus.req_size);

    load_extend u_extend (
        .i_rdata  (s_bus.mem_rdata),
        .i_addr   (r_addr),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ext)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = w_mis ? HOLD : WAIT;
            WAIT:    if (s_bus.mem_rvalid) w_next = HOLD;
            HOLD:    if (s_bus.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rd_en <= w_hs && !w_mis;
            if (w_hs) begin
                r_addr   <= s_bus.req_addr;
                r_size   <= size_e'(s_bus.req_size);
                r_signed <= s_bus.req_signed;
                r_err    <= w_mis;
                r_data   <= '0;
            end else if ((r_state == WAIT) && s_bus.mem_rvalid) begin
                r_data <= w_ext;
                r_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_aligner.sv
// Scoreboard bench for load_aligner: directed corner loads, random loads and
// a reset-during-WAIT scenario against an arithmetic reference model.
module tb_load_aligner;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t q[$];

    load_aligner_if #(.DATA_W(32)) bus ();

    load_aligner #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .s_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick bytes addr..addr+size from the word, then extend.
    function automatic exp_t ref_load(input logic [1:0] a, input logic [1:0] s,
                                      input bit sg, input logic [31:0] w);
        exp_t r;
        int ia = a;
        int nb = int'(s) + 1;
        longint unsigned wv = w;
        longint v;
        if (ia + nb > 4) begin
            r.d = 32'h0;
            r.e = 1'b1;
            return r;
        end
        v = longint'((wv >> (8 * ia)) % (longint'(1) << (8 * nb)));
        if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        r.d = v[31:0];
        r.e = 1'b0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.resp_valid && bus.resp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got data %h err %0d want no response",
                         bus.resp_data, bus.resp_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_data", bus.resp_data, e.d);
                chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.e});
            end
        end
    end

    task automatic do_load(input logic [1:0] a, input logic [1:0] s, input bit sg,
                           input logic [31:0] w, input int dly, input int hold_cyc);
        exp_t e;
        e = ref_load(a, s, sg, w);
        bus.req_valid  = 1'b1;
        bus.req_addr   = a;
        bus.req_size   = s;
        bus.req_signed = sg;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        q.push_back(e);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 2'($urandom);
        bus.req_size  = 2'($urandom);
        if (!e.e) begin
            for (int d = 0; d <= dly; d++) begin
                if (d == dly) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = w;
                end
                @(negedge clk);
                chk("mem_rd_en_pulse", {31'b0, bus.mem_rd_en}, (d == 0) ? 32'd1 : 32'd0);
                chk("resp_valid_early", {31'b0, bus.resp_valid}, 32'd0);
                @(posedge clk); #1;
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        for (int h = 0; h <= hold_cyc; h++) begin
            if (h == hold_cyc) bus.resp_ready = 1'b1;
            @(negedge clk);
            chk("resp_valid_hold", {31'b0, bus.resp_valid}, 32'd1);
            chk("resp_data_stable", bus.resp_data, e.d);
            chk("req_ready_busy", {31'b0, bus.req_ready}, 32'd0);
            chk("mem_rd_en_hold", {31'b0, bus.mem_rd_en}, 32'd0);
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_valid_after", {31'b0, bus.resp_valid}, 32'd0);
        chk("req_ready_after", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 2'd0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_mem_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;

        do_load(2'd0, 2'b00, 1'b1, 32'h8899AABB, 0, 0);
        do_load(2'd0, 2'b00, 1'b0, 32'h8899AABB, 1, 0);
        do_load(2'd2, 2'b01, 1'b1, 32'h8899AABB, 0, 0);
        do_load(2'd2, 2'b01, 1'b0, 32'h8899AABB, 2, 0);
        do_load(2'd0, 2'b11, 1'b1, 32'h8899AABB, 0, 0);
        do_load(2'd3, 2'b01, 1'b0, 32'h8899AABB, 0, 0);
        do_load(2'd1, 2'b10, 1'b1, 32'h8899AABB, 1, 3);
        do_load(2'd3, 2'b00, 1'b1, 32'h8899AABB, 0, 3);

        for (int i = 0; i < 60; i++) begin
            do_load(2'($urandom), 2'($urandom), 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Reset while waiting for memory; the late read data must be dropped.
        bus.req_valid  = 1'b1;
        bus.req_addr   = 2'd0;
        bus.req_size   = 2'b11;
        bus.req_signed = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk("rst_wait_req_ready_after", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_wait_no_resp", {31'b0, bus.resp_valid}, 32'd0);
            chk("rst_wait_no_rd", {31'b0, bus.mem_rd_en}, 32'd0);
            @(posedge clk); #1;
        end

        do_load(2'd1, 2'b01, 1'b1, 32'h12F4_5678, 1, 1);

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
